// File: rtl/iob_pcie_rx_engine.sv
// iob_pcie_rx_engine
// Receive-side controller for one RIFFA-style PCIe channel. Detects a new
// transaction, pulses ACK and latches LEN/OFF/LAST, then drains data beats
// into a first-word-fall-through beat FIFO while counting valid 32-bit words
// against LEN. The FIFO feeds a downsizer that presents a 32-bit
// valid/ready word stream to the CPU-side register block.
//
// Ports
//   clk, arst_n            clock, asynchronous active-low reset
//   chnl_rx_*              RIFFA RX channel (transaction, data, ren, ack)
//   rd_data_o/valid/ready  32-bit output word stream
//   len_o/off_o/last_o     latched transaction fields
//   words_o                words accepted in the current/last transaction
//   level_o                FIFO occupancy in beats
//   busy_o                 FSM not idle
//   done_o                 one-cycle completion pulse
//   trunc_o / clear_i      sticky early-termination flag and its clear
module iob_pcie_rx_engine #(
  parameter int PCI_DATA_W  = 64,
  parameter int FIFO_ADDR_W = 5,
  parameter int LEN_W       = 32
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   chnl_rx_i,
  input  logic                   chnl_rx_last_i,
  input  logic [LEN_W-1:0]       chnl_rx_len_i,
  input  logic [30:0]            chnl_rx_off_i,
  input  logic [PCI_DATA_W-1:0]  chnl_rx_data_i,
  input  logic                   chnl_rx_data_valid_i,
  output logic                   chnl_rx_data_ren_o,
  output logic                   chnl_rx_ack_o,
  output logic [31:0]            rd_data_o,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic [LEN_W-1:0]       len_o,
  output logic [30:0]            off_o,
  output logic                   last_o,
  output logic [LEN_W-1:0]       words_o,
  output logic [FIFO_ADDR_W:0]   level_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   trunc_o,
  input  logic                   clear_i
);

  localparam int W     = PCI_DATA_W / 32;
  localparam int DEPTH = 1 << FIFO_ADDR_W;
  localparam int N_W   = $clog2(W + 1);
  localparam int WI_W  = (W > 1) ? $clog2(W) : 1;
  localparam logic [FIFO_ADDR_W:0] LVL_FULL = {1'b1, {FIFO_ADDR_W{1'b0}}};

  // each FIFO entry carries its beat and the count of valid words in it
  typedef struct packed {
    logic [N_W-1:0]        n;
    logic [PCI_DATA_W-1:0] data;
  } beat_t;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_RECV, S_DONE} state_t;

  state_t                 r_state;
  logic [LEN_W-1:0]       r_len, r_words;
  logic [30:0]            r_off;
  logic                   r_last, r_ack, r_ren, r_done, r_trunc;

  beat_t                  r_mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] r_wptr, r_rptr;
  logic [FIFO_ADDR_W:0]   r_level;
  logic [WI_W-1:0]        r_widx;

  logic                   w_accept, w_pop, w_last_word, w_rvalid, w_full_nxt;
  logic [LEN_W-1:0]       w_remain, w_words_nxt;
  logic [N_W-1:0]         w_n;
  logic [FIFO_ADDR_W:0]   w_level_nxt;
  beat_t                  w_head;
  logic [W-1:0][31:0]     w_head_words;

  // ---------------------------------------------------------------------------
  // beat accounting: n = min(W, len - words) trims the final partial beat
  // ---------------------------------------------------------------------------
  assign w_accept    = r_ren & chnl_rx_data_valid_i;
  assign w_remain    = r_len - r_words;
  assign w_n         = (w_remain < LEN_W'(W)) ? w_remain[N_W-1:0] : N_W'(W);
  assign w_words_nxt = r_words + (w_accept ? LEN_W'(w_n) : '0);

  // ---------------------------------------------------------------------------
  // FIFO head / downsizer
  // ---------------------------------------------------------------------------
  assign w_rvalid     = (r_level != '0);
  assign w_head       = r_mem[r_rptr];
  assign w_head_words = w_head.data;
  assign w_last_word  = ((N_W'(r_widx) + N_W'(1)) == w_head.n);
  assign w_pop        = w_rvalid & rd_ready_i & w_last_word;

  assign w_level_nxt = r_level + {{FIFO_ADDR_W{1'b0}}, w_accept}
                               - {{FIFO_ADDR_W{1'b0}}, w_pop};
  // ren is registered, so it looks ahead at the occupancy after this edge;
  // a pop in the cycle the FIFO is full cannot make room for a same-cycle push
  assign w_full_nxt  = (w_level_nxt == LVL_FULL);

  always_ff @(posedge clk)
    if (w_accept) r_mem[r_wptr] <= '{n: w_n, data: chnl_rx_data_i};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_widx  <= '0;
    end else begin
      r_level <= w_level_nxt;
      if (w_accept) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_widx <= '0;
      end else if (w_rvalid & rd_ready_i) begin
        r_widx <= r_widx + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // transaction FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_off   <= '0;
      r_last  <= 1'b0;
      r_words <= '0;
      r_ack   <= 1'b0;
      r_ren   <= 1'b0;
      r_done  <= 1'b0;
      r_trunc <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_done <= 1'b0;
      // a truncation set below overrides this clear
      if (clear_i) r_trunc <= 1'b0;
      case (r_state)
        S_IDLE: if (chnl_rx_i) begin
          r_len   <= chnl_rx_len_i;
          r_off   <= chnl_rx_off_i;
          r_last  <= chnl_rx_last_i;
          r_words <= '0;
          r_ack   <= 1'b1;
          r_state <= S_ACK;
        end
        S_ACK: if (r_len == '0) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end else begin
          r_state <= S_RECV;
          r_ren   <= ~w_full_nxt;
        end
        S_RECV: begin
          r_words <= w_words_nxt;
          if (w_words_nxt >= r_len) begin
            // ren drops with the final word so no extra beat is consumed
            r_state <= S_DONE;
            r_ren   <= 1'b0;
            r_done  <= 1'b1;
          end else if (!chnl_rx_i) begin
            r_state <= S_DONE;
            r_ren   <= 1'b0;
            r_done  <= 1'b1;
            r_trunc <= 1'b1;
          end else begin
            r_ren   <= ~w_full_nxt;
          end
        end
        S_DONE: if (!chnl_rx_i) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign chnl_rx_data_ren_o = r_ren;
  assign chnl_rx_ack_o      = r_ack;
  assign rd_valid_o         = w_rvalid;
  assign rd_data_o          = w_rvalid ? w_head_words[r_widx] : '0;
  assign len_o              = r_len;
  assign off_o              = r_off;
  assign last_o             = r_last;
  assign words_o            = r_words;
  assign level_o            = r_level;
  assign busy_o             = (r_state != S_IDLE);
  assign done_o             = r_done;
  assign trunc_o            = r_trunc;

endmodule

// File: tb/tb_iob_pcie_rx_engine.sv
// Bench for iob_pcie_rx_engine: stimulus tasks push expected words into a
// scoreboard queue; a monitor pops and compares on every accepted word.
module tb_iob_pcie_rx_engine;
  localparam int PCI_DATA_W  = 64;
  localparam int FIFO_ADDR_W = 5;
  localparam int LEN_W       = 32;
  localparam int W           = PCI_DATA_W / 32;
  localparam int DEPTH       = 1 << FIFO_ADDR_W;

  logic                  clk = 1'b0;
  logic                  arst_n;
  logic                  chnl_rx_i, chnl_rx_last_i, chnl_rx_data_valid_i;
  logic [LEN_W-1:0]      chnl_rx_len_i;
  logic [30:0]           chnl_rx_off_i;
  logic [PCI_DATA_W-1:0] chnl_rx_data_i;
  logic                  chnl_rx_data_ren_o, chnl_rx_ack_o;
  logic [31:0]           rd_data_o;
  logic                  rd_valid_o, rd_ready_i;
  logic [LEN_W-1:0]      len_o, words_o;
  logic [30:0]           off_o;
  logic                  last_o, busy_o, done_o, trunc_o, clear_i;
  logic [FIFO_ADDR_W:0]  level_o;

  iob_pcie_rx_engine #(.PCI_DATA_W(PCI_DATA_W), .FIFO_ADDR_W(FIFO_ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .arst_n(arst_n),
    .chnl_rx_i(chnl_rx_i), .chnl_rx_last_i(chnl_rx_last_i),
    .chnl_rx_len_i(chnl_rx_len_i), .chnl_rx_off_i(chnl_rx_off_i),
    .chnl_rx_data_i(chnl_rx_data_i), .chnl_rx_data_valid_i(chnl_rx_data_valid_i),
    .chnl_rx_data_ren_o(chnl_rx_data_ren_o), .chnl_rx_ack_o(chnl_rx_ack_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .len_o(len_o), .off_o(off_o), .last_o(last_o), .words_o(words_o),
    .level_o(level_o), .busy_o(busy_o), .done_o(done_o), .trunc_o(trunc_o),
    .clear_i(clear_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int rd_mode  = 2;              // 0: ready low, 1: random, 2: ready high
  logic [31:0]           exp_q[$];
  logic [PCI_DATA_W-1:0] fixed_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_flags"}, {chnl_rx_data_ren_o, chnl_rx_ack_o, rd_valid_o, busy_o,
                            done_o, trunc_o, last_o}, 0);
    check({tag, "_len"},   len_o, 0);
    check({tag, "_off"},   off_o, 0);
    check({tag, "_words"}, words_o, 0);
    check({tag, "_level"}, level_o, 0);
    check({tag, "_data"},  rd_data_o, 0);
  endtask

  // reader: drives rd_ready_i according to rd_mode
  initial begin
    rd_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rd_mode)
        0:       rd_ready_i = 1'b0;
        1:       rd_ready_i = 1'($urandom_range(0, 1));
        default: rd_ready_i = 1'b1;
      endcase
    end
  end

  // scoreboard monitor
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (arst_n && rd_valid_o) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_unexpected: got word 0x%0h expected none", rd_data_o);
        end else if (rd_ready_i) begin
          e = exp_q.pop_front();
          check("sb_word", rd_data_o, e);
        end else begin
          check("sb_hold", rd_data_o, exp_q[0]);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done_o) done_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drain();
    int c;
    c = 0;
    if (rd_mode == 0) rd_mode = 2;
    while ((exp_q.size() != 0 || rd_valid_o) && c < 3000) begin
      @(negedge clk); c++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_level", level_o, 0);
  endtask

  task automatic run_txn(input int len, input int trunc_after, input bit bp, input bit rst_mode);
    logic [30:0]           off;
    logic                  last;
    logic [PCI_DATA_W-1:0] data;
    int mw, beats, cyc, n, d0;
    bit have, exp_trunc, bp_done;
    off = 31'($urandom); last = 1'($urandom_range(0, 1));
    mw = 0; beats = 0; cyc = 0; d0 = done_cnt; data = '0;
    have = 0; exp_trunc = 0; bp_done = 0;

    @(posedge clk); #1;
    chnl_rx_i = 1'b1; chnl_rx_len_i = LEN_W'(len); chnl_rx_off_i = off; chnl_rx_last_i = last;
    @(negedge clk);
    check("ack_early", chnl_rx_ack_o, 0);
    @(negedge clk);
    check("ack", chnl_rx_ack_o, 1);
    check("busy", busy_o, 1);
    check("len_o", len_o, len);
    check("off_o", off_o, off);
    check("last_o", last_o, last);
    check("words_clr", words_o, 0);
    @(negedge clk);
    check("ack_drop", chnl_rx_ack_o, 0);
    check("ren_start", chnl_rx_data_ren_o, len != 0);

    if (len == 0) begin
      check("len0_done", done_o, 1);
      check("len0_rvalid", rd_valid_o, 0);
    end else begin
      while (mw < len && beats != trunc_after) begin
        @(posedge clk); #1;
        if (!have) begin
          data = (fixed_q.size() != 0) ? fixed_q.pop_front() : {$urandom, $urandom};
          have = 1;
        end
        chnl_rx_data_i = data;
        chnl_rx_data_valid_i = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (chnl_rx_data_ren_o && chnl_rx_data_valid_i) begin
          n = (len - mw < W) ? len - mw : W;
          for (int k = 0; k < n; k++) exp_q.push_back(data[32*k +: 32]);
          mw += n; beats++; have = 0;
          if (bp && !bp_done && beats == DEPTH) begin
            @(posedge clk); #1; chnl_rx_data_valid_i = 1'b0;
            @(negedge clk);
            check("bp_level", level_o, DEPTH);
            check("bp_ren", chnl_rx_data_ren_o, 0);
            repeat (3) @(negedge clk);
            check("bp_ren_hold", chnl_rx_data_ren_o, 0);
            check("bp_level_hold", level_o, DEPTH);
            bp_done = 1; rd_mode = 1;
          end
        end
        cyc++;
        if (cyc > 4000) begin
          n_checks++; n_fail++;
          $display("FAIL feed_timeout: got %0d words expected %0d", mw, len);
          break;
        end
      end
      @(posedge clk); #1; chnl_rx_data_valid_i = 1'b0;
      if (rst_mode) begin
        @(negedge clk);
        check("rst_level_pre", level_o, beats);
        #2 arst_n = 1'b0;
        #1 check_zero("rst_mid");
        exp_q.delete(); chnl_rx_i = 1'b0;
        @(posedge clk); #1 arst_n = 1'b1;
        @(negedge clk);
        check_zero("rst_after");
        return;
      end
      exp_trunc = (mw < len);
      if (exp_trunc) begin
        chnl_rx_i = 1'b0;
        @(negedge clk);
        check("done_pre_trunc", done_o, 0);
      end
      @(negedge clk);
      check("done", done_o, 1);
      check("ren_end", chnl_rx_data_ren_o, 0);
    end
    check("trunc", trunc_o, exp_trunc);
    check("words_o", words_o, mw);
    if (chnl_rx_i) begin
      @(posedge clk); #1; chnl_rx_i = 1'b0;
      @(negedge clk);
      check("done_once", done_o, 0);
      check("ren_done", chnl_rx_data_ren_o, 0);
    end
    @(negedge clk);
    check("idle", busy_o, 0);
    check("done_cnt", done_cnt - d0, 1);
    if (exp_trunc) begin
      @(posedge clk); #1; clear_i = 1'b1;
      @(negedge clk);
      check("trunc_sticky", trunc_o, 1);
      @(posedge clk); #1; clear_i = 1'b0;
      @(negedge clk);
      check("trunc_clear", trunc_o, 0);
    end
  endtask

  initial begin
    int len, nb, ta;
    arst_n = 1'b0; chnl_rx_i = 1'b0; chnl_rx_last_i = 1'b0; chnl_rx_len_i = '0;
    chnl_rx_off_i = '0; chnl_rx_data_i = '0; chnl_rx_data_valid_i = 1'b0; clear_i = 1'b0;
    #12 check_zero("reset");
    @(posedge clk); #1 arst_n = 1'b1;

    // basic len=4 with known beats
    rd_mode = 2;
    fixed_q.push_back(64'h00000001_00000000);
    fixed_q.push_back(64'h00000003_00000002);
    run_txn(4, -1, 0, 0);
    drain();

    // partial final beat: 0xD must be dropped
    fixed_q.push_back(64'h0000000B_0000000A);
    fixed_q.push_back(64'h0000000D_0000000C);
    run_txn(3, -1, 0, 0);
    drain();

    // backpressure fills the FIFO
    rd_mode = 0;
    run_txn(100, -1, 1, 0);
    drain();

    // truncation after 2 beats, then clear
    rd_mode = 1;
    run_txn(8, 2, 0, 0);
    drain();

    // zero length
    run_txn(0, -1, 0, 0);
    drain();

    // reset with 5 beats buffered, then a normal transaction
    rd_mode = 0;
    run_txn(20, 5, 0, 1);
    rd_mode = 2;
    run_txn(2, -1, 0, 0);
    drain();

    // randomized, FIFO left draining across pairs of transactions
    for (int i = 0; i < 14; i++) begin
      rd_mode = $urandom_range(1, 2);
      len = $urandom_range(1, 20);
      nb = (len + W - 1) / W;
      ta = (nb > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, nb - 1) : -1;
      run_txn(len, ta, 0, 0);
      if (i % 2 == 1) drain();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
